// File: rtl/step_ctrl_pkg.sv
// rtl/step_ctrl_pkg.sv - shared types and helpers for the step controller
// Purpose: FSM state and mode encodings, plus the burst-length decode.
// Ports: none (package).
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_BURST = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    M_SINGLE = 2'd0,
    M_BURST  = 2'd1,
    M_RUN    = 2'd2,
    M_BREAK  = 2'd3
  } mode_t;

  // A burst length of zero is the full 256-step burst.
  function automatic logic [8:0] burst_total(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser plus stable-count debouncer
// Purpose: accepts a new button level only after DEBOUNCE_CYCLES consecutive
//          synchronised samples that differ from the current level.
// Ports:
//   clk    in  system clock
//   resetn in  synchronous reset, active-low
//   raw    in  asynchronous, bouncing button input
//   level  out debounced button level
//   press  out registered one-cycle pulse on a rising debounced edge
module button_debouncer
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        // cnt holds how many differing samples came before this one
        if (cnt == LAST) begin
          level <= sync2;
          press <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/step_controller.sv
// rtl/step_controller.sv - button-driven step sequencer for the Core
// Purpose: single-step, N-step burst, free-run and run-to-breakpoint control
//          of the Core step input, with halt status and a step counter.
// Ports:
//   clk        in  system clock
//   resetn     in  synchronous reset, active-low
//   btn_step   in  raw step button
//   btn_run    in  raw run/halt toggle button
//   mode       in  00 single, 01 burst, 10 run, 11 run-to-break
//   burst_len  in  steps per burst, 0 means 256
//   break_pc   in  breakpoint address
//   core_pc    in  current Core PC
//   step       out registered one-cycle step pulse to the Core
//   halted     out 1 while idle
//   state_o    out current FSM state encoding
//   step_count out steps issued since reset, wrapping
module step_controller
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV         = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        btn_step,
  input  logic        btn_run,
  input  logic [1:0]  mode,
  input  logic [7:0]  burst_len,
  input  logic [31:0] break_pc,
  input  logic [31:0] core_pc,
  output logic        step,
  output logic        halted,
  output logic [1:0]  state_o,
  output logic [31:0] step_count
);

  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(RUN_DIV - 1);

  logic step_level;
  logic step_press;
  logic run_level;
  logic run_press;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk    (clk),
    .resetn (resetn),
    .raw    (btn_step),
    .level  (step_level),
    .press  (step_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk    (clk),
    .resetn (resetn),
    .raw    (btn_run),
    .level  (run_level),
    .press  (run_press)
  );

  state_t        state, state_n;
  mode_t         mode_r, mode_n, mode_in;
  logic [DW-1:0] div, div_n;
  logic [8:0]    rem, rem_n;
  logic          step_n;

  assign mode_in = mode_t'(mode);

  // All decisions are made one edge ahead: step_n is the pulse for the cycle
  // that follows the edge, so step is a plain register. div is the pacing
  // phase of that following cycle; the entry edge is phase 0.
  always_comb begin
    state_n = state;
    mode_n  = mode_r;
    rem_n   = rem;
    step_n  = 1'b0;
    div_n   = (div == DLAST) ? '0 : div + 1'b1;
    case (state)
      S_IDLE: begin
        div_n = '0;
        if (run_press && mode_in[1]) begin
          state_n = S_RUN;
          mode_n  = mode_in;
          step_n  = 1'b1;  // first run step is unconditional: leaves a breakpoint
        end else if (step_press && mode_in == M_SINGLE) begin
          state_n = S_STEP;
          mode_n  = mode_in;
          step_n  = 1'b1;
        end else if (step_press && mode_in == M_BURST) begin
          state_n = S_BURST;
          mode_n  = mode_in;
          rem_n   = burst_total(burst_len) - 9'd1;
          step_n  = 1'b1;
        end
      end
      S_STEP: begin
        state_n = S_IDLE;
      end
      S_BURST: begin
        if (run_press || rem == 9'd0) begin
          state_n = S_IDLE;
        end else if (div_n == '0) begin
          step_n = 1'b1;
          rem_n  = rem - 9'd1;
        end
      end
      S_RUN: begin
        if (run_press) begin
          state_n = S_IDLE;
        end else if (div_n == '0) begin
          if (mode_r == M_BREAK && core_pc == break_pc) begin
            state_n = S_IDLE;
          end else begin
            step_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      mode_r     <= M_SINGLE;
      div        <= '0;
      rem        <= '0;
      step       <= 1'b0;
      step_count <= '0;
    end else begin
      state  <= state_n;
      mode_r <= mode_n;
      div    <= div_n;
      rem    <= rem_n;
      step   <= step_n;
      if (step_n) begin
        step_count <= step_count + 32'd1;
      end
    end
  end

  assign halted  = (state == S_IDLE);
  assign state_o = state;

endmodule

// File: tb/tb_step_controller.sv
// tb/tb_step_controller.sv - self-checking bench for step_controller
module tb_step_controller;

  localparam int D  = 4;
  localparam int RD = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        btn_step;
  logic        btn_run;
  logic [1:0]  mode;
  logic [7:0]  burst_len;
  logic [31:0] break_pc;
  logic [31:0] core_pc;
  logic        step;
  logic        halted;
  logic [1:0]  state_o;
  logic [31:0] step_count;
  logic        pc_clr;

  int checks = 0;
  int failures = 0;

  step_controller #(.DEBOUNCE_CYCLES(D), .RUN_DIV(RD)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_step   (btn_step),
    .btn_run    (btn_run),
    .mode       (mode),
    .burst_len  (burst_len),
    .break_pc   (break_pc),
    .core_pc    (core_pc),
    .step       (step),
    .halted     (halted),
    .state_o    (state_o),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  // Core stand-in: PC advances by 4 on every step it receives.
  always @(posedge clk) begin
    if (pc_clr) core_pc <= 32'd0;
    else if (step) core_pc <= core_pc + 32'd4;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Debounce: the sample seen at edge k is the raw value from edge k-2; the
  // level flips once the last D samples all disagree with it.
  // Sequencer: an active job remembers its entry edge; steps fall on edges
  // whose distance from entry is a multiple of RD.
  bit    m_valid = 0;
  int    m_state;            // 0 idle, 1 single, 2 burst, 3 run
  int    m_start, m_issued, m_limit, cyc;
  bit    m_brk, m_step;
  bit    p_run, p_step;
  bit    lvl [2];
  bit    np [2];
  logic [15:0] rh [2];
  logic [15:0] sh [2];
  logic [31:0] m_count;
  localparam logic [15:0] DMASK = 16'((1 << D) - 1);

  always @(posedge clk) begin
    if (!resetn) begin
      m_valid = 1; m_state = 0; m_step = 0; m_count = 0; cyc = 0;
      p_run = 0; p_step = 0;
      for (int b = 0; b < 2; b++) begin lvl[b] = 0; rh[b] = '0; sh[b] = '0; end
    end else begin
      m_step = 0;
      case (m_state)
        0: begin
          if (p_run && mode[1]) begin
            m_state = 3; m_start = cyc; m_brk = (mode == 2'b11); m_step = 1;
          end else if (p_step && mode == 2'b00) begin
            m_state = 1; m_step = 1;
          end else if (p_step && mode == 2'b01) begin
            m_state = 2; m_start = cyc; m_issued = 1; m_step = 1;
            m_limit = (burst_len == 0) ? 256 : int'(burst_len);
          end
        end
        1: m_state = 0;
        2: begin
          if (p_run || m_issued == m_limit) m_state = 0;
          else if ((cyc - m_start) % RD == 0) begin m_step = 1; m_issued++; end
        end
        default: begin
          if (p_run) m_state = 0;
          else if ((cyc - m_start) % RD == 0) begin
            if (m_brk && core_pc == break_pc) m_state = 0;
            else m_step = 1;
          end
        end
      endcase
      if (m_step) m_count = m_count + 32'd1;
      for (int b = 0; b < 2; b++) begin
        sh[b] = {sh[b][14:0], rh[b][1]};
        np[b] = 0;
        if (((sh[b] ^ {16{~lvl[b]}}) & DMASK) == 16'd0) begin
          lvl[b] = ~lvl[b];
          np[b] = lvl[b];
        end
      end
      rh[0] = {rh[0][14:0], btn_step};
      rh[1] = {rh[1][14:0], btn_run};
      p_step = np[0];
      p_run  = np[1];
      cyc++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("step", {31'd0, step}, {31'd0, m_step});
      check("halted", {31'd0, halted}, (m_state == 0) ? 32'd1 : 32'd0);
      check("state_o", {30'd0, state_o}, 32'(m_state));
      check("step_count", step_count, m_count);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit is_run);
    if (is_run) btn_run = 1'b1; else btn_step = 1'b1;
    wait_cyc(8);
    if (is_run) btn_run = 1'b0; else btn_step = 1'b0;
    wait_cyc(8);
  endtask

  initial begin
    resetn = 1'b0; btn_step = 1'b0; btn_run = 1'b0; mode = 2'b00;
    burst_len = 8'd0; break_pc = 32'd0; pc_clr = 1'b1;
    wait_cyc(3);
    check("reset_halted", {31'd0, halted}, 32'd1);
    check("reset_state", {30'd0, state_o}, 32'd0);
    check("reset_count", step_count, 32'd0);
    resetn = 1'b1; pc_clr = 1'b0;
    wait_cyc(4);

    // bouncing single step
    mode = 2'b00;
    for (int i = 0; i < 10; i++) begin btn_step = (i % 2 == 0); wait_cyc(1); end
    btn_step = 1'b1; wait_cyc(10); btn_step = 1'b0; wait_cyc(10);
    check("single_count", step_count, 32'd1);
    check("single_model", m_count, 32'd1);
    check("single_halted", {31'd0, halted}, 32'd1);

    // burst of 5, then burst of 256
    mode = 2'b01; burst_len = 8'd5;
    press(1'b0); wait_cyc(20);
    check("burst5_count", step_count, 32'd6);
    check("burst5_halted", {31'd0, halted}, 32'd1);
    burst_len = 8'd0;
    press(1'b0); wait_cyc(256 * RD + 10);
    check("burst256_count", step_count, 32'd262);
    check("burst256_model", m_count, 32'd262);

    // free run for 30 cycles, step press and mode change ignored
    mode = 2'b10;
    btn_run = 1'b1; wait_cyc(8); btn_run = 1'b0;
    btn_step = 1'b1; mode = 2'b01; wait_cyc(8); btn_step = 1'b0; mode = 2'b10;
    wait_cyc(14);
    btn_run = 1'b1; wait_cyc(8); btn_run = 1'b0; wait_cyc(12);
    check("run_count", step_count, 32'd272);
    check("run_halted", {31'd0, halted}, 32'd1);

    // run to breakpoint, then leave it
    mode = 2'b11; break_pc = 32'h10;
    pc_clr = 1'b1; wait_cyc(1); pc_clr = 1'b0;
    press(1'b1); wait_cyc(30);
    check("break_halted", {31'd0, halted}, 32'd1);
    check("break_pc_hit", core_pc, 32'h10);
    check("break_count", step_count, 32'd276);
    btn_run = 1'b1; wait_cyc(7);
    check("break_exit_step", {31'd0, step}, 32'd1);
    check("break_exit_state", {30'd0, state_o}, 32'd3);
    btn_run = 1'b0; wait_cyc(12);
    press(1'b1); wait_cyc(10);
    check("break_exit_stop", {31'd0, halted}, 32'd1);

    // randomised button traffic
    for (int it = 0; it < 60; it++) begin
      mode = 2'($urandom_range(0, 3));
      burst_len = 8'($urandom_range(1, 6));
      break_pc = 32'(4 * $urandom_range(0, 10));
      if ($urandom_range(0, 4) == 0) pc_clr = 1'b1;
      btn_step = 1'($urandom_range(0, 1));
      btn_run  = ($urandom_range(0, 2) == 0);
      wait_cyc(1); pc_clr = 1'b0;
      wait_cyc($urandom_range(1, 14));
    end
    btn_step = 1'b0; btn_run = 1'b0;
    wait_cyc(20);

    // simultaneous presses, then reset mid-run
    resetn = 1'b0; wait_cyc(2); resetn = 1'b1; wait_cyc(2);
    mode = 2'b10;
    btn_step = 1'b1; btn_run = 1'b1; wait_cyc(7);
    check("simul_state", {30'd0, state_o}, 32'd3);
    btn_step = 1'b0; btn_run = 1'b0; wait_cyc(5);
    resetn = 1'b0; wait_cyc(1);
    check("midrun_reset_step", {31'd0, step}, 32'd0);
    check("midrun_reset_count", step_count, 32'd0);
    check("midrun_reset_state", {30'd0, state_o}, 32'd0);
    resetn = 1'b1; wait_cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
